// File: rtl/ffa_uart_pkg.sv
// Shared types and constants for the FFA result UART transmitter.
// Defining FFA_UART_PARITY_EN adds an even-parity bit to every byte frame (8E1).
package ffa_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef FFA_UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

`ifdef FFA_UART_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    localparam int unsigned BYTES_PER_WORD = 4;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                      input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT clocks while enabled and pulses bit_done_c
// on the last clock of each bit. restart_i re-aligns the count to a new word.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    input  logic en_i,
    output logic bit_done_c
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done_c = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ffa_result_uart_tx.sv
// Sends each accepted 32-bit result word as four UART byte frames, MSB byte first.
// Build option FFA_UART_PARITY_EN inserts an even-parity bit after the data bits.
module ffa_result_uart_tx
    import ffa_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [31:0] tx_data,
    output logic        tx_busy,
    output logic        uart_txd
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned IDX_W  = 2;

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cfg
            $error("ffa_result_uart_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    uart_state_e       state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic [BYTE_W-1:0] cur_byte;
    logic              accept_c;
    logic              bit_done_c;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart_i  (accept_c),
        .en_i       (state_q != ST_IDLE),
        .bit_done_c (bit_done_c)
    );

    // Next state; line and busy are derived from the next state so both are registered.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        accept_c   = 1'b0;
        busy_d     = 1'b0;
        txd_d      = 1'b1;
        cur_byte   = '0;

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    accept_c   = 1'b1;
                    shift_d    = tx_data;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_done_c) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done_c) begin
                    if (bit_idx_q == BIT_W'(7)) begin
                        bit_idx_d = '0;
`ifdef FFA_UART_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end
            end
`ifdef FFA_UART_PARITY_EN
            ST_PARITY: begin
                if (bit_done_c) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done_c) begin
                    if (byte_idx_q != IDX_W'(BYTES_PER_WORD - 1)) begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                        shift_d    = {shift_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cur_byte = shift_d[WORD_W-1 -: BYTE_W];
        busy_d   = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = cur_byte[bit_idx_d];
`ifdef FFA_UART_PARITY_EN
            ST_PARITY: txd_d = ^cur_byte;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_busy  = busy_q;
    assign uart_txd = txd_q;

endmodule

// File: tb/tb_ffa_result_uart_tx.sv
// Bench for ffa_result_uart_tx at 10 clocks per bit; expected line levels come from
// a frame-level model of the word (start, LSB-first data, optional parity, stop).
module tb_ffa_result_uart_tx;

`ifdef FFA_UART_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int CPB   = 10;
    localparam int WORD_CYCLES = 4 * F * CPB;

    logic        clk;
    logic        rst_n;
    logic        tx_start;
    logic [31:0] tx_data;
    logic        tx_busy;
    logic        uart_txd;

    int checks = 0;
    int errors = 0;
    logic [7:0] dec_bytes [4];
    logic [3:0] dec_par;

    ffa_result_uart_tx #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD_RATE   (100_000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .uart_txd (uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level for bit-slot n of word w.
    function automatic logic exp_bit(input logic [31:0] w, input int n);
        int bi;
        int pos;
        logic [7:0] b;
        bi  = n / F;
        pos = n % F;
        b   = w[31 - 8*bi -: 8];
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (pos == F - 1) return 1'b1;
        return ^b;
    endfunction

    // Sends w starting at a negedge with the DUT idle; returns at the negedge of the
    // first idle cycle (or after a mid-word reset when rst_cycle is reached).
    task automatic xmit(input logic [31:0] w, input int ign_cycle, input int rst_cycle,
                        input string tag);
        int n;
        int pos;
        tx_data  = w;
        tx_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= WORD_CYCLES; c++) begin
            if (c == rst_cycle) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s async_reset cycle %0d: txd=%b busy=%b, required txd=1 busy=0",
                             tag, c, uart_txd, tx_busy);
                end
                tx_start = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            n = (c - 1) / CPB;
            checks++;
            if (tx_busy !== 1'b1 || uart_txd !== exp_bit(w, n)) begin
                errors++;
                $display("FAIL %s line cycle %0d: txd=%b busy=%b, required txd=%b busy=1",
                         tag, c, uart_txd, tx_busy, exp_bit(w, n));
            end
            if ((c - 1) % CPB == CPB / 2) begin
                pos = n % F;
                if (pos >= 1 && pos <= 8) dec_bytes[n / F][pos - 1] = uart_txd;
                if (F == 11 && pos == 9) dec_par[n / F] = uart_txd;
            end
            tx_start = (c == ign_cycle);
            tx_data  = (c == ign_cycle) ? 32'hDEAD_BEEF : 32'($urandom);
            @(negedge clk);
        end
        tx_start = 1'b0;
        checks++;
        if (tx_busy !== 1'b0 || uart_txd !== 1'b1) begin
            errors++;
            $display("FAIL %s end_of_word: txd=%b busy=%b, required txd=1 busy=0",
                     tag, uart_txd, tx_busy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dec_bytes[i] !== w[31 - 8*i -: 8]) begin
                errors++;
                $display("FAIL %s byte%0d: got %h, required %h", tag, i, dec_bytes[i],
                         w[31 - 8*i -: 8]);
            end
        end
    endtask

    task automatic check_idle(input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            checks++;
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
                errors++;
                $display("FAIL %s cycle %0d: txd=%b busy=%b, required txd=1 busy=0",
                         tag, c, uart_txd, tx_busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        tx_start = 1'b1;
        tx_data  = 32'($urandom);
        #1;
        check_idle(20, "reset_hold");
        tx_start = 1'b0;
        rst_n    = 1'b1;
        check_idle(30, "post_reset_idle");
    endtask

    task automatic test_single_word();
        xmit(32'h0000_0636, -1, -1, "single");
    endtask

    task automatic test_ignore_busy();
        xmit(32'h1357_9BDF, 150, -1, "ignore_busy");
        check_idle(5, "ignore_busy_idle");
    endtask

    task automatic test_back_to_back();
        xmit(32'($urandom), -1, -1, "b2b_first");
        xmit(32'hA5A5_5A5A, -1, -1, "b2b_second");
        check_idle(3, "b2b_idle");
    endtask

    task automatic test_mid_word_reset();
        xmit(32'hFFFF_FFFF, -1, 215, "mid_reset");
        check_idle(10, "mid_reset_idle");
        xmit(32'($urandom), -1, -1, "after_reset");
    endtask

    task automatic test_random_words();
        for (int i = 0; i < 3; i++) begin
            xmit(32'($urandom), -1, -1, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

`ifdef FFA_UART_PARITY_EN
    task automatic test_parity();
        xmit(32'h0102_0307, -1, -1, "parity");
        checks++;
        if (dec_par !== 4'b1011) begin
            errors++;
            $display("FAIL parity_bits: got %b (byte3..byte0), required 1011", dec_par);
        end
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        tx_start = 1'b0;
        tx_data  = '0;
        dec_par  = '0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_ignore_busy();
        test_back_to_back();
        test_mid_word_reset();
        test_random_words();
`ifdef FFA_UART_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
